// File: rtl/ddr3_frame_writer_if.sv
// Pixel stream input and Avalon-MM burst write bus of the DDR3 frame writer.
// The master modport is the writer's side; slave is the source/memory side.
interface ddr3_frame_writer_if;
    logic [23:0]  pix_data_in;
    logic         pix_valid_in;
    logic         pix_sof_in;
    logic         pix_ready_out;
    logic         ddr3_emif_ready;
    logic         ddr3_emif_write;
    logic [24:0]  ddr3_emif_addr;
    logic [255:0] ddr3_emif_write_data;
    logic [31:0]  ddr3_emif_byte_enable;
    logic [4:0]   ddr3_emif_burst_count;

    modport master (
        input  pix_data_in, pix_valid_in, pix_sof_in, ddr3_emif_ready,
        output pix_ready_out, ddr3_emif_write, ddr3_emif_addr,
               ddr3_emif_write_data, ddr3_emif_byte_enable, ddr3_emif_burst_count
    );

    modport slave (
        output pix_data_in, pix_valid_in, pix_sof_in, ddr3_emif_ready,
        input  pix_ready_out, ddr3_emif_write, ddr3_emif_addr,
               ddr3_emif_write_data, ddr3_emif_byte_enable, ddr3_emif_burst_count
    );
endinterface

// File: rtl/ddr3_frame_writer.sv
// Packs a 24-bit pixel stream ten pixels per 256-bit word and writes frames
// to DDR3 as contiguous Avalon-MM bursts from a programmed start address.
module ddr3_frame_writer #(
    parameter int unsigned BURST_LEN    = 8,
    parameter int unsigned FIFO_DEPTH   = 32,
    parameter int unsigned PIX_PER_WORD = 10
) (
    input  logic                       mem_clk,
    input  logic                       mem_rst_n,
    input  logic                       start_in,
    input  logic                       abort_in,
    input  logic [24:0]                start_addr_in,
    input  logic [31:0]                frame_num_in,
    input  logic [31:0]                frame_pix_in,
    output logic                       busy_out,
    output logic                       write_done_out,
    output logic                       sync_err_out,
    ddr3_frame_writer_if.master        bus
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [2:0] {IDLE, WAIT_SOF, RUN, FLUSH, DONE} state_t;
    state_t state, state_nxt;

    logic [31:0]   frames_left, frame_pix, pix_cnt;
    logic [24:0]   wr_addr;
    logic [3:0]    slot;
    logic [239:0]  pack_word, pack_nxt;
    logic          push_vld;
    logic [255:0]  push_word;

    logic [255:0]  mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] fifo_cnt, cnt_nxt, free_cnt, go_len;

    logic          in_burst;
    logic [4:0]    burst_len, beats_left;
    logic          start_acc, pix_acc, take_pix, last_pix, word_done;
    logic          beat, last_beat, burst_go;

    assign start_acc = (state == IDLE) && start_in && !abort_in;
    assign free_cnt  = CW'(FIFO_DEPTH) - fifo_cnt;
    assign bus.pix_ready_out = (state == WAIT_SOF) ||
                               ((state == RUN) && (free_cnt >= CW'(2)));
    assign pix_acc   = bus.pix_valid_in && bus.pix_ready_out && !abort_in;
    assign take_pix  = pix_acc && ((state == RUN) || bus.pix_sof_in);
    assign last_pix  = (state == RUN) ? (pix_cnt == frame_pix - 32'd1)
                                      : (frame_pix == 32'd1);
    assign word_done = take_pix && ((slot == 4'(PIX_PER_WORD - 1)) || last_pix);

    always_comb begin
        pack_nxt = pack_word;
        pack_nxt[24*int'(slot) +: 24] = bus.pix_data_in;
    end

    assign beat      = in_burst && bus.ddr3_emif_ready;
    assign last_beat = beat && (beats_left == 5'd1);
    assign cnt_nxt   = fifo_cnt + CW'(push_vld) - CW'(beat);
    // Decide on post-cycle occupancy so a word landing this cycle joins the
    // burst and a new burst can follow the final beat with no idle cycle.
    assign burst_go  = (!in_burst || last_beat) && !abort_in &&
                       ((cnt_nxt >= CW'(BURST_LEN)) || ((state == FLUSH) && (cnt_nxt != '0)));
    assign go_len    = (cnt_nxt >= CW'(BURST_LEN)) ? CW'(BURST_LEN) : cnt_nxt;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (start_in)
                          state_nxt = ((frame_num_in == '0) || (frame_pix_in == '0)) ? DONE : WAIT_SOF;
            WAIT_SOF: if (take_pix) state_nxt = last_pix ? FLUSH : RUN;
            RUN:      if (take_pix && last_pix) state_nxt = FLUSH;
            FLUSH:    if ((fifo_cnt == '0) && !push_vld && !in_burst)
                          state_nxt = (frames_left == 32'd1) ? DONE : WAIT_SOF;
            DONE:     state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
        if (abort_in) state_nxt = IDLE;
    end

    always_ff @(posedge mem_clk or negedge mem_rst_n) begin
        if (!mem_rst_n) state <= IDLE;
        else            state <= state_nxt;
    end

    always_ff @(posedge mem_clk or negedge mem_rst_n) begin
        if (!mem_rst_n) begin
            frames_left    <= '0;
            frame_pix      <= '0;
            pix_cnt        <= '0;
            slot           <= '0;
            pack_word      <= '0;
            push_vld       <= 1'b0;
            push_word      <= '0;
            sync_err_out   <= 1'b0;
            write_done_out <= 1'b0;
        end else begin
            push_vld       <= word_done;
            write_done_out <= (state == DONE) && !abort_in;
            if (word_done) push_word <= {16'h0000, pack_nxt};
            if (abort_in || start_acc) begin
                slot      <= '0;
                pack_word <= '0;
            end else if (take_pix) begin
                slot      <= word_done ? 4'd0 : slot + 4'd1;
                pack_word <= word_done ? '0 : pack_nxt;
            end
            if (take_pix) pix_cnt <= (state == RUN) ? pix_cnt + 32'd1 : 32'd1;
            if (start_acc) begin
                frames_left  <= frame_num_in;
                frame_pix    <= frame_pix_in;
                sync_err_out <= 1'b0;
            end else if (pix_acc && (state == RUN) && bus.pix_sof_in) begin
                sync_err_out <= 1'b1;
            end
            if ((state == FLUSH) && (state_nxt == WAIT_SOF)) frames_left <= frames_left - 32'd1;
        end
    end

    always_ff @(posedge mem_clk) begin
        if (push_vld) mem[wr_ptr] <= push_word;
    end

    always_ff @(posedge mem_clk or negedge mem_rst_n) begin
        if (!mem_rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else if (abort_in) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push_vld) wr_ptr <= wr_ptr + 1'b1;
            if (beat)     rd_ptr <= rd_ptr + 1'b1;
            fifo_cnt <= cnt_nxt;
        end
    end

    always_ff @(posedge mem_clk or negedge mem_rst_n) begin
        if (!mem_rst_n) begin
            in_burst   <= 1'b0;
            burst_len  <= '0;
            beats_left <= '0;
            wr_addr    <= '0;
        end else if (start_acc) begin
            wr_addr  <= start_addr_in;
            in_burst <= 1'b0;
        end else if (abort_in) begin
            in_burst <= 1'b0;
        end else begin
            if (last_beat) wr_addr <= wr_addr + 25'(burst_len);
            if (burst_go) begin
                in_burst   <= 1'b1;
                burst_len  <= 5'(go_len);
                beats_left <= 5'(go_len);
            end else if (last_beat) begin
                in_burst <= 1'b0;
            end else if (beat) begin
                beats_left <= beats_left - 5'd1;
            end
        end
    end

    assign busy_out                  = (state != IDLE);
    assign bus.ddr3_emif_write       = in_burst;
    assign bus.ddr3_emif_addr        = wr_addr;
    assign bus.ddr3_emif_burst_count = burst_len;
    assign bus.ddr3_emif_write_data  = in_burst ? mem[rd_ptr] : '0;
    assign bus.ddr3_emif_byte_enable = '1;
endmodule

// File: tb/tb_ddr3_frame_writer.sv
// Directed bench for ddr3_frame_writer: packing, burst sizing, back-pressure,
// address wrap, sync errors, zero-length jobs and abort.
module tb_ddr3_frame_writer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start, abort;
    logic [24:0] saddr;
    logic [31:0] fnum, fpix;
    logic        busy, done, serr;

    ddr3_frame_writer_if bus ();

    ddr3_frame_writer #(.BURST_LEN(8), .FIFO_DEPTH(32), .PIX_PER_WORD(10)) dut (
        .mem_clk        (clk),
        .mem_rst_n      (rst_n),
        .start_in       (start),
        .abort_in       (abort),
        .start_addr_in  (saddr),
        .frame_num_in   (fnum),
        .frame_pix_in   (fpix),
        .busy_out       (busy),
        .write_done_out (done),
        .sync_err_out   (serr),
        .bus            (bus)
    );

    always #5 clk = ~clk;

    int unsigned  n_checks = 0, n_pass = 0, done_cnt = 0, bidx = 0;
    int           rdy_mode = 0;
    logic [255:0] q_data[$];
    logic [24:0]  q_addr[$];
    logic [4:0]   q_cnt[$];
    logic         prev_stall = 1'b0, prev_abort = 1'b0;
    logic [24:0]  prev_addr = '0;
    logic [4:0]   prev_cnt = '0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, got, exp);
    endtask

    function automatic logic [23:0] pv(input int unsigned f, input int unsigned i);
        return {4'hA, f[3:0], i[15:0]};
    endfunction

    function automatic logic [255:0] exp_word(input int unsigned f, input int unsigned w, input int unsigned n);
        logic [255:0] r = '0;
        for (int unsigned k = 0; k < 10; k++)
            if (w * 10 + k < n) r[24*k +: 24] = pv(f, w * 10 + k);
        return r;
    endfunction

    // Beat/burst recorder and burst-hold checker, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_stall && !prev_abort)
                check("burst_hold", {bus.ddr3_emif_write, bus.ddr3_emif_addr, bus.ddr3_emif_burst_count},
                      {1'b1, prev_addr, prev_cnt});
            prev_stall = bus.ddr3_emif_write && !bus.ddr3_emif_ready;
            prev_abort = abort;
            prev_addr  = bus.ddr3_emif_addr;
            prev_cnt   = bus.ddr3_emif_burst_count;
            if (done) done_cnt++;
            if (abort) bidx = 0;
            else if (bus.ddr3_emif_write && bus.ddr3_emif_ready) begin
                if (bidx == 0) begin
                    q_addr.push_back(bus.ddr3_emif_addr);
                    q_cnt.push_back(bus.ddr3_emif_burst_count);
                end
                q_data.push_back(bus.ddr3_emif_write_data);
                bidx = (bidx + 1 == int'(bus.ddr3_emif_burst_count)) ? 0 : bidx + 1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        case (rdy_mode)
            0:       bus.ddr3_emif_ready = 1'b1;
            1:       bus.ddr3_emif_ready = ~bus.ddr3_emif_ready;
            default: bus.ddr3_emif_ready = 1'b0;
        endcase
    endtask

    task automatic clear_q();
        q_data.delete();
        q_addr.delete();
        q_cnt.delete();
    endtask

    task automatic run_start(input logic [24:0] a, input logic [31:0] nf, input logic [31:0] np);
        saddr = a; fnum = nf; fpix = np; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_pix(input logic [23:0] d, input logic s);
        int unsigned n = 0;
        bus.pix_valid_in = 1'b1;
        bus.pix_data_in  = d;
        bus.pix_sof_in   = s;
        while (!bus.pix_ready_out && n < 2000) begin
            tick();
            n++;
        end
        if (n >= 2000) check("pix_accept_timeout", n, 0);
        tick();
        bus.pix_valid_in = 1'b0;
        bus.pix_sof_in   = 1'b0;
    endtask

    task automatic send_frame(input int unsigned f, input int n, input int sof2);
        for (int i = 0; i < n; i++) send_pix(pv(f, i), (i == 0) || (i == sof2));
    endtask

    task automatic wait_done(input string tag);
        int unsigned n = 0;
        while (!done && n < 5000) begin
            tick();
            n++;
        end
        check({tag, "_done"}, done, 1'b1);
        tick();
        check({tag, "_done_one_cycle"}, {done, busy}, 2'b00);
    endtask

    initial begin
        int unsigned idx, stall, mism, snap, sum;
        logic [24:0] exp_a;
        start = 1'b0; abort = 1'b0; saddr = '0; fnum = '0; fpix = '0;
        bus.pix_valid_in = 1'b0; bus.pix_sof_in = 1'b0; bus.pix_data_in = '0;
        bus.ddr3_emif_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ctrl", {bus.ddr3_emif_write, bus.pix_ready_out, busy, done, serr}, 5'b0);
        check("rst_addr_cnt", {bus.ddr3_emif_addr, bus.ddr3_emif_burst_count}, 30'h0);
        check("rst_wdata", bus.ddr3_emif_write_data, 256'h0);
        check("byte_en", bus.ddr3_emif_byte_enable, 32'hFFFF_FFFF);
        rst_n = 1'b1;
        tick();

        // 1 frame x 20 pixels: a single 2-beat burst
        clear_q();
        run_start(25'h100, 32'd1, 32'd20);
        check("t1_busy", busy, 1'b1);
        send_frame(1, 20, -1);
        wait_done("t1");
        check("t1_bursts", {q_addr.size(), q_data.size()}, {32'd1, 32'd2});
        check("t1_addr_cnt", {q_addr[0], q_cnt[0]}, {25'h100, 5'd2});
        check("t1_w0_pix0", q_data[0][23:0], 24'hA10000);
        check("t1_w1_pix19", q_data[1][239:216], 24'hA10013);
        check("t1_w0_upper", q_data[0][255:240], 16'h0);
        check("t1_w0", q_data[0], exp_word(1, 0, 20));
        check("t1_w1", q_data[1], exp_word(1, 1, 20));
        check("t1_sync_err", serr, 1'b0);

        // 25 pixels: final word is zero-padded
        clear_q();
        run_start(25'h200, 32'd1, 32'd25);
        send_frame(2, 25, -1);
        wait_done("t2");
        check("t2_addr_cnt", {q_addr[0], q_cnt[0], 32'(q_data.size())}, {25'h200, 5'd3, 32'd3});
        check("t2_w2_pad", q_data[2][255:120], 136'h0);
        check("t2_w2", q_data[2], exp_word(2, 2, 25));

        // 2 frames x 100 pixels with ready toggling
        clear_q();
        rdy_mode = 1;
        run_start(25'h100, 32'd2, 32'd100);
        send_frame(3, 100, -1);
        send_frame(4, 100, -1);
        wait_done("t3");
        rdy_mode = 0;
        check("t3_nbursts", {q_cnt.size(), q_data.size()}, {32'd4, 32'd20});
        check("t3_cnts", {q_cnt[0], q_cnt[1], q_cnt[2], q_cnt[3]}, {5'd8, 5'd2, 5'd8, 5'd2});
        check("t3_addrs", {q_addr[0], q_addr[1], q_addr[2], q_addr[3]},
              {25'h100, 25'h108, 25'h10A, 25'h112});
        for (int unsigned w = 0; w < 20; w++)
            check($sformatf("t3_word%0d", w), q_data[w], exp_word(w < 10 ? 3 : 4, w % 10, 100));

        // Pixels before the first sof are discarded
        clear_q();
        tick();
        run_start(25'h300, 32'd1, 32'd10);
        for (int unsigned i = 0; i < 5; i++) send_pix(pv(15, i), 1'b0);
        send_frame(5, 10, -1);
        wait_done("t4");
        check("t4_beats", {q_data.size(), q_addr[0], q_cnt[0]}, {32'd1, 25'h300, 5'd1});
        check("t4_word", q_data[0], exp_word(5, 0, 10));

        // Stray sof inside a frame is data and sets the sticky error
        clear_q();
        run_start(25'h340, 32'd1, 32'd10);
        send_frame(6, 10, 3);
        wait_done("ts");
        check("ts_sync_err", serr, 1'b1);
        check("ts_word", q_data[0], exp_word(6, 0, 10));

        // Ready held low: intake stalls before overflow; then drain across the address wrap
        clear_q();
        rdy_mode = 2;
        run_start(25'h1FF_FFFC, 32'd1, 32'd400);
        check("t5_sync_err_cleared", serr, 1'b0);
        idx = 0; stall = 0;
        bus.pix_valid_in = 1'b1;
        while (stall < 20 && idx < 400) begin
            bus.pix_data_in = pv(7, idx);
            bus.pix_sof_in  = (idx == 0);
            if (bus.pix_ready_out) begin
                tick();
                idx++;
                stall = 0;
            end else begin
                tick();
                stall++;
            end
        end
        bus.pix_valid_in = 1'b0;
        check("t5_accepted_before_stall", idx, 311);
        check("t5_pix_ready_low", bus.pix_ready_out, 1'b0);
        check("t5_no_beats", q_data.size(), 0);
        rdy_mode = 0;
        for (int unsigned i = idx; i < 400; i++) send_pix(pv(7, i), 1'b0);
        wait_done("t5");
        check("t5_beats", q_data.size(), 40);
        check("t5_first_addr", q_addr[0], 25'h1FF_FFFC);
        exp_a = 25'h1FF_FFFC; mism = 0; sum = 0;
        foreach (q_addr[b]) begin
            if (q_addr[b] !== exp_a) mism++;
            exp_a = exp_a + 25'(q_cnt[b]);
            sum += q_cnt[b];
        end
        check("t5_addr_contig", mism, 0);
        check("t5_cnt_sum_end", {sum, exp_a}, {32'd40, 25'h24});
        mism = 0;
        for (int unsigned w = 0; w < 40; w++)
            if (q_data[w] !== exp_word(7, w, 400)) mism++;
        check("t5_data_mismatches", mism, 0);

        // Zero-length jobs finish without writing
        clear_q();
        run_start(25'h10, 32'd0, 32'd10);
        check("z1_done_not_yet", done, 1'b0);
        tick();
        check("z1_done_pulse", done, 1'b1);
        tick();
        run_start(25'h10, 32'd3, 32'd0);
        tick();
        check("z2_done_pulse", done, 1'b1);
        tick();
        check("z_no_writes", q_data.size(), 0);

        // Abort in the middle of a stalled burst, then restart elsewhere
        clear_q();
        rdy_mode = 2;
        run_start(25'h400, 32'd1, 32'd100);
        send_frame(9, 85, -1);
        tick();
        check("t6_write_before_abort", bus.ddr3_emif_write, 1'b1);
        snap = done_cnt;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t6_after_abort", {bus.ddr3_emif_write, busy, bus.pix_ready_out}, 3'b000);
        rdy_mode = 0;
        repeat (5) tick();
        check("t6_no_done", done_cnt, snap);
        check("t6_no_beats", q_data.size(), 0);
        run_start(25'h500, 32'd1, 32'd10);
        send_frame(8, 10, -1);
        wait_done("t6r");
        check("t6r_addr_cnt", {q_data.size(), q_addr[0], q_cnt[0]}, {32'd1, 25'h500, 5'd1});
        check("t6r_word", q_data[0], exp_word(8, 0, 10));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
